// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the byte requesters, the transmit scheduler and
// the UART shifter. The scheduler connects through the slave view. The
// requester/shifter side (or a test environment) uses the master view.
interface uart_tx_scheduler_if;
    logic [1:0]  req;
    logic [7:0]  data0;
    logic [7:0]  data1;
    logic [1:0]  parity_type;
    logic        data_length;
    logic        stop_bits;
    logic        ser_tx_active;
    logic        ser_tx_done;
    logic [11:0] frame_out;
    logic        send;
    logic [1:0]  ack;
    logic        grant_id;
    logic        busy;
    logic        err_timeout;

    modport master (
        output req, data0, data1, parity_type, data_length, stop_bits,
               ser_tx_active, ser_tx_done,
        input  frame_out, send, ack, grant_id, busy, err_timeout
    );

    modport slave (
        input  req, data0, data1, parity_type, data_length, stop_bits,
               ser_tx_active, ser_tx_done,
        output frame_out, send, ack, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-channel round-robin transmit scheduler feeding a UART shifter.
// It grants one requester and builds the 12-bit frame on the grant edge.
// It holds send until the shifter reports active, then waits for done.
// After done it inserts a configurable idle gap before re-arbitrating.
module uart_tx_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 2,
    parameter int CNT_W          = 12
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             prio;       // channel favoured when both request
    logic             done_seen;  // done arrived together with active
    logic             sel_ch;
    logic [11:0]      frame_next;

    // Parity and field layout for the currently requested byte and config.
    function automatic logic [11:0] build_frame(
        input logic [7:0] data,
        input logic [1:0] ptype,
        input logic       eight_bit,
        input logic       two_stop
    );
        logic [7:0] active_bits;
        logic [7:0] field;
        logic       par;
        // In 7-bit mode bit 7 is excluded from parity and bit 3 is padded with mark.
        active_bits = eight_bit ? data : {1'b0, data[6:0]};
        field       = eight_bit ? data : {data[6:0], 1'b1};
        case (ptype)
            2'b01:   par = ~^active_bits;
            2'b10:   par = ^active_bits;
            default: par = 1'b1;
        endcase
        // Bit 0 is mark for both stop settings; the shifter owns the stop count.
        return {1'b0, field, par, 1'b1, two_stop | 1'b1};
    endfunction

    // Pick the requester and pre-build its frame for the grant edge.
    always_comb begin
        sel_ch = 1'b0;
        if (bus.req == 2'b11) begin
            sel_ch = prio;
        end else begin
            sel_ch = bus.req[1];
        end
        frame_next = build_frame(sel_ch ? bus.data1 : bus.data0,
                                 bus.parity_type, bus.data_length, bus.stop_bits);
    end

    // Scheduler FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            prio            <= 1'b0;
            done_seen       <= 1'b0;
            bus.frame_out   <= 12'hFFF;
            bus.send        <= 1'b0;
            bus.ack         <= 2'b00;
            bus.grant_id    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.ack         <= 2'b00;
            bus.err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.grant_id  <= sel_ch;
                        bus.frame_out <= frame_next;
                        bus.send      <= 1'b1;
                        bus.busy      <= 1'b1;
                        cnt           <= '0;
                        done_seen     <= 1'b0;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    // Active wins over a simultaneous timeout.
                    if (bus.ser_tx_active) begin
                        bus.ack   <= bus.grant_id ? 2'b10 : 2'b01;
                        prio      <= ~bus.grant_id;
                        bus.send  <= 1'b0;
                        done_seen <= bus.ser_tx_done;
                        cnt       <= '0;
                        state     <= WAIT_DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        // Abort without ack; pointer stays so the same channel is re-served.
                        bus.err_timeout <= 1'b1;
                        bus.send        <= 1'b0;
                        bus.busy        <= 1'b0;
                        cnt             <= '0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.ser_tx_done || done_seen) begin
                        cnt       <= '0;
                        done_seen <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed-plus-random bench for the UART transmit scheduler. The bench
// plays the requesters and the shifter. Expected frames and grants come from
// a behavioural model based on bit counting and a favoured-channel variable.
module tb_uart_tx_scheduler;

    localparam int TO  = 8;
    localparam int GAP = 2;

    logic clk;
    logic rst;
    uart_tx_scheduler_if bus ();

    uart_tx_scheduler #(
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES    (GAP),
        .CNT_W         (12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int pref        = 0;  // channel the model expects to win a tie

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Reference frame built from the field rules using plain arithmetic.
    function automatic logic [11:0] model_frame(input logic [7:0] b, input logic [1:0] pt,
                                                input logic dl);
        int ones;
        int nbits;
        int field;
        int par;
        ones  = 0;
        nbits = dl ? 8 : 7;
        for (int i = 0; i < nbits; i++) ones += int'(b[i]);
        field = dl ? int'(b) : (int'(b) % 128) * 2 + 1;
        if (pt == 2'b01)      par = (ones % 2 == 0) ? 1 : 0;
        else if (pt == 2'b10) par = ones % 2;
        else                  par = 1;
        return 12'(field * 8 + par * 4 + 3);
    endfunction

    function automatic int model_grant(input logic [1:0] r);
        if (r == 2'b11) return pref;
        return r[1] ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete frame: grant, active handshake, ack, done and gap.
    task automatic run_frame(input logic [1:0] rq, input int act_delay,
                             input logic [11:0] exp_frame, input int exp_ch,
                             input bit flip_cfg, input bit drop_req, input int exp_wait);
        int n;
        n = 0;
        bus.req = rq;
        while (bus.send !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait", n, exp_wait);
        check("grant_id", bus.grant_id, exp_ch);
        check("frame_out", bus.frame_out, exp_frame);
        check("busy_load", bus.busy, 1);
        if (flip_cfg) bus.parity_type = 2'b01;
        for (int i = 0; i < act_delay; i++) begin
            @(negedge clk);
            check("send_hold", bus.send, 1);
        end
        bus.ser_tx_active = 1'b1;
        @(negedge clk);
        check("ack", bus.ack, (exp_ch == 1) ? 2 : 1);
        check("send_drop", bus.send, 0);
        check("frame_hold", bus.frame_out, exp_frame);
        $display("frame ch%0d frame_out=%03h wait=%0d act_delay=%0d", exp_ch, bus.frame_out,
                 n, act_delay);
        pref = 1 - exp_ch;
        bus.ser_tx_active = 1'b0;
        bus.ser_tx_done   = 1'b1;
        if (drop_req) bus.req = 2'b00;
        for (int k = 1; k <= GAP + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.ser_tx_done = 1'b0;
                check("ack_pulse", bus.ack, 0);
            end
            check("busy_gap", bus.busy, (k <= GAP) ? 1 : 0);
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [1:0]  r;
        logic [1:0]  pt;
        logic        dl;
        int          ch;
        int          cnt;

        rst = 1'b0;
        bus.req = 2'b00;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
        bus.parity_type = 2'b00;
        bus.data_length = 1'b1;
        bus.stop_bits = 1'b0;
        bus.ser_tx_active = 1'b0;
        bus.ser_tx_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_frame", bus.frame_out, 12'hFFF);
        check("rst_send", bus.send, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_grant", bus.grant_id, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err_timeout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Contention: both channels held, alternating grants starting with ch0.
        bus.data0 = 8'h11;
        bus.data1 = 8'h22;
        bus.parity_type = 2'b00;
        for (int i = 0; i < 4; i++) begin
            ch = model_grant(2'b11);
            run_frame(2'b11, 1, model_frame(ch == 1 ? 8'h22 : 8'h11, 2'b00, 1'b1), ch,
                      1'b0, (i == 3), 1);
        end

        // Single request, 8-bit even parity, active after three cycles.
        bus.data0 = 8'hA5;
        bus.parity_type = 2'b10;
        bus.data_length = 1'b1;
        run_frame(2'b01, 3, 12'h52B, 0, 1'b0, 1'b1, 1);

        // 7-bit odd parity on channel 1.
        bus.data1 = 8'h7F;
        bus.data_length = 1'b0;
        bus.parity_type = 2'b01;
        run_frame(2'b10, 2, model_frame(8'h7F, 2'b01, 1'b0), 1, 1'b0, 1'b1, 1);

        // Config change after grant leaves the frame alone; the next frame uses it.
        b = 8'h3C;
        bus.data0 = b;
        bus.data_length = 1'b1;
        bus.parity_type = 2'b10;
        run_frame(2'b01, 2, model_frame(b, 2'b10, 1'b1), 0, 1'b1, 1'b1, 1);
        run_frame(2'b01, 1, model_frame(b, 2'b01, 1'b1), 0, 1'b0, 1'b1, 1);

        // Timeout: shifter never goes active, the same channel is re-granted.
        bus.data0 = 8'h5A;
        bus.data1 = 8'hC3;
        bus.parity_type = 2'b10;
        bus.data_length = 1'b1;
        ch = model_grant(2'b11);
        bus.req = 2'b11;
        @(negedge clk);
        check("to_send", bus.send, 1);
        cnt = 0;
        while (bus.send === 1'b1 && cnt < 40) begin
            check("to_noack", bus.ack, 0);
            cnt++;
            @(negedge clk);
        end
        $display("timeout ch%0d send_cycles=%0d err=%0d", ch, cnt, bus.err_timeout);
        check("to_cycles", cnt, TO);
        check("to_err", bus.err_timeout, 1);
        check("to_ack", bus.ack, 0);
        check("to_busy", bus.busy, 0);
        @(negedge clk);
        check("to_err_pulse", bus.err_timeout, 0);
        run_frame(2'b11, 1, model_frame(ch == 1 ? 8'hC3 : 8'h5A, 2'b10, 1'b1), ch,
                  1'b0, 1'b1, 0);

        // Randomised requests, bytes and configurations.
        for (int i = 0; i < 12; i++) begin
            r  = 2'($urandom_range(1, 3));
            pt = 2'($urandom_range(0, 3));
            dl = 1'($urandom_range(0, 1));
            bus.data0 = 8'($urandom);
            bus.data1 = 8'($urandom);
            bus.parity_type = pt;
            bus.data_length = dl;
            bus.stop_bits = 1'($urandom_range(0, 1));
            ch = model_grant(r);
            b  = (ch == 1) ? bus.data1 : bus.data0;
            run_frame(r, $urandom_range(0, 5), model_frame(b, pt, dl), ch, 1'b0, 1'b1, 1);
        end

        // Reset while waiting for done; ch0 regains priority afterwards.
        bus.data0 = 8'h81;
        bus.data1 = 8'h18;
        bus.parity_type = 2'b00;
        bus.data_length = 1'b1;
        ch = model_grant(2'b11);
        bus.req = 2'b11;
        @(negedge clk);
        check("rw_send", bus.send, 1);
        check("rw_grant", bus.grant_id, ch);
        bus.ser_tx_active = 1'b1;
        @(negedge clk);
        check("rw_ack", bus.ack, (ch == 1) ? 2 : 1);
        bus.ser_tx_active = 1'b0;
        rst = 1'b1;
        #1;
        check("rw_rst_send", bus.send, 0);
        check("rw_rst_busy", bus.busy, 0);
        check("rw_rst_frame", bus.frame_out, 12'hFFF);
        check("rw_rst_ack", bus.ack, 0);
        $display("reset in wait_done: send=%0d busy=%0d frame_out=%03h", bus.send, bus.busy,
                 bus.frame_out);
        @(negedge clk);
        rst = 1'b0;
        pref = 0;
        run_frame(2'b11, 2, model_frame(8'h81, 2'b00, 1'b1), 0, 1'b0, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
